// File: rtl/seg7_scan_controller_if.sv
// Load channel of the 7-segment scan controller: one nibble per digit,
// transferred with a valid/ready handshake.
interface seg7_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a bank of 7-segment digits with
// per-slot blanking and frame-aligned display updates.
module seg7_scan_controller #(
    parameter int  NUM_DIGITS       = 4,
    parameter int  CLK_DIV          = 100000,
    parameter int  BLANK_CYCLES     = 16,
    parameter bit  ANODE_ACTIVE_LOW = 1'b1,
    localparam int IDX_W            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    seg7_scan_controller_if.slave    load_if,
    input  logic [NUM_DIGITS-1:0]    digit_en,
    output logic [3:0]               digit_nibble,
    output logic [NUM_DIGITS-1:0]    anode,
    output logic [IDX_W-1:0]         digit_idx,
    output logic                     frame_done
);

    localparam int MAX_LEN = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  =
        ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   display_q, display_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic                      pending_valid_q, pending_valid_d;
    logic [3:0]                nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0]     anode_q, anode_d;
    logic                      frame_done_q, frame_done_d;

    logic                      accept;
    logic                      last_show;
    logic [NUM_DIGITS-1:0]     sel;
    logic [NUM_DIGITS-1:0]     show_mask;

    assign load_if.load_ready = ~pending_valid_q;
    assign accept             = load_if.load_valid & ~pending_valid_q;
    assign last_show          = (state_q == ST_SHOW) && (idx_q == IDX_LAST)
                                && (cnt_q == SHOW_LAST);

    // Outputs are computed from the next-state values so that the registered
    // anode/nibble change on the same edge that enters each state.
    always_comb begin
        // NOTE: every signal written here gets a default first; a missed branch
        // would otherwise infer a latch.
        state_d         = state_q;
        cnt_d           = cnt_q + 1'b1;
        idx_d           = idx_q;
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Accept is impossible while pending is full, so the two branches never collide.
        if (last_show && pending_valid_q) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end else if (accept) begin
            pending_d       = load_if.load_data;
            pending_valid_d = 1'b1;
        end

        nibble_d     = display_d[{idx_d, 2'b00} +: 4];
        sel          = NUM_DIGITS'(1) << idx_d;
        show_mask    = (state_d == ST_SHOW) ? (sel & digit_en) : '0;
        anode_d      = ANODE_ACTIVE_LOW ? ~show_mask : show_mask;
        frame_done_d = (state_d == ST_SHOW) && (idx_d == IDX_LAST)
                       && (cnt_d == SHOW_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_BLANK;
            cnt_q           <= '0;
            idx_q           <= '0;
            // NOTE: the display bank is reset explicitly so the first frame after
            // reset shows zeros instead of whatever was latched before.
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            nibble_q        <= '0;
            anode_q         <= ANODE_OFF;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            nibble_q        <= nibble_d;
            anode_q         <= anode_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign digit_nibble = nibble_q;
    assign anode        = anode_q;
    assign digit_idx    = idx_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller: slot/frame arithmetic model,
// table-driven scan timing, hand-written load/reset sequences, random traffic.
module tb_seg7_scan_controller;

    localparam int N     = 4;
    localparam int CD    = 5;
    localparam int BL    = 2;
    localparam int SLOT  = BL + CD;
    localparam int FRAME = N * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_en;
    logic [3:0] digit_nibble;
    logic [3:0] anode;
    logic [1:0] digit_idx;
    logic       frame_done;

    seg7_scan_controller_if #(.NUM_DIGITS(N)) load_if ();

    seg7_scan_controller #(
        .NUM_DIGITS      (N),
        .CLK_DIV         (CD),
        .BLANK_CYCLES    (BL),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_if     (load_if),
        .digit_en    (digit_en),
        .digit_nibble(digit_nibble),
        .anode       (anode),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    // Reference model: cycle index since reset plus display/pending contents.
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    logic [3:0]  m_en_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0d, time=%0t)", name, act, exp, t, $time);
        end
    endtask

    task automatic compare_model();
        int         slot;
        int         dig;
        logic [3:0] ea;
        logic [15:0] sh;
        slot = t % SLOT;
        dig  = (t / SLOT) % N;
        ea   = 4'hF;
        if (slot >= BL && m_en_prev[dig]) ea[dig] = 1'b0;
        sh = m_disp >> (4 * dig);
        check("anode", anode, ea);
        check("digit_idx", digit_idx, dig);
        check("digit_nibble", digit_nibble, sh[3:0]);
        check("frame_done", frame_done, (t % FRAME) == FRAME - 1);
        check("load_ready", load_if.load_ready, !m_pv);
    endtask

    // Crosses one rising edge, updating the model with the inputs seen there.
    task automatic cycle_end();
        @(posedge clk);
        if (rst) begin
            t      = 0;
            m_disp = '0;
            m_pend = '0;
            m_pv   = 1'b0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end else if (load_if.load_valid && !m_pv) begin
                m_pend = load_if.load_data;
                m_pv   = 1'b1;
            end
            t++;
        end
        m_en_prev = digit_en;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
        cycle_end();
    endtask

    task automatic run_until(input int target);
        int guard = 0;
        while (t < target && guard < 1000) begin
            step();
            guard++;
        end
        check("run_until", t, target);
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [3:0] anode;
        logic       fd;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{0,  4'hF, 4'hF, 1'b0, 2'd0};
        vecs[1]  = '{1,  4'hF, 4'hF, 1'b0, 2'd0};
        vecs[2]  = '{2,  4'hF, 4'hE, 1'b0, 2'd0};
        vecs[3]  = '{6,  4'hF, 4'hE, 1'b0, 2'd0};
        vecs[4]  = '{7,  4'hF, 4'hF, 1'b0, 2'd1};
        vecs[5]  = '{9,  4'hF, 4'hD, 1'b0, 2'd1};
        vecs[6]  = '{16, 4'hF, 4'hB, 1'b0, 2'd2};
        vecs[7]  = '{23, 4'hF, 4'h7, 1'b0, 2'd3};
        vecs[8]  = '{26, 4'hF, 4'h7, 1'b0, 2'd3};
        vecs[9]  = '{27, 4'hF, 4'h7, 1'b1, 2'd3};
        vecs[10] = '{28, 4'hF, 4'hF, 1'b0, 2'd0};
        vecs[11] = '{55, 4'hF, 4'h7, 1'b1, 2'd3};

        rst                = 1'b1;
        load_if.load_valid = 1'b0;
        load_if.load_data  = '0;
        digit_en           = 4'hF;
        m_en_prev          = 4'hF;
        t                  = 0;
        cycle_end();
        cycle_end();
        rst = 1'b0;

        // Reset state and scan timing with all digits enabled.
        for (int i = 0; i < 12; i++) begin
            digit_en = vecs[i].en;
            run_until(vecs[i].cyc);
            @(negedge clk);
            compare_model();
            check("tbl_anode", anode, vecs[i].anode);
            check("tbl_frame_done", frame_done, vecs[i].fd);
            check("tbl_idx", digit_idx, vecs[i].idx);
            if (i == 0) begin
                check("rst_nibble", digit_nibble, 4'h0);
                check("rst_ready", load_if.load_ready, 1'b1);
            end
            cycle_end();
        end

        // Mid-frame load shows up only after the boundary.
        run_until(66);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h4321;
        @(negedge clk); compare_model();
        check("ld_ready_before", load_if.load_ready, 1'b1);
        cycle_end();
        load_if.load_valid = 1'b0;
        @(negedge clk); compare_model();
        check("ld_ready_drop", load_if.load_ready, 1'b0);
        check("ld_old_nibble", digit_nibble, 4'h0);
        cycle_end();
        run_until(83);
        @(negedge clk); compare_model();
        check("ld_boundary_fd", frame_done, 1'b1);
        cycle_end();
        @(negedge clk); compare_model();
        check("ld_nib0", digit_nibble, 4'h1);
        check("ld_ready_back", load_if.load_ready, 1'b1);
        cycle_end();
        run_until(93);
        @(negedge clk); compare_model();
        check("ld_nib1", digit_nibble, 4'h2);
        check("ld_an1", anode, 4'hD);
        cycle_end();
        run_until(98);
        @(negedge clk); compare_model();
        check("ld_nib2", digit_nibble, 4'h3);
        cycle_end();
        run_until(108);
        @(negedge clk); compare_model();
        check("ld_nib3", digit_nibble, 4'h4);
        cycle_end();

        // Second load held by the source while pending is full.
        run_until(112);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'hAAAA;
        @(negedge clk); compare_model();
        check("hold_first_ready", load_if.load_ready, 1'b1);
        cycle_end();
        load_if.load_data = 16'hBBBB;
        @(negedge clk); compare_model();
        check("hold_blocked", load_if.load_ready, 1'b0);
        cycle_end();
        run_until(139);
        @(negedge clk); compare_model();
        check("hold_fd", frame_done, 1'b1);
        cycle_end();
        @(negedge clk); compare_model();
        check("hold_ready_after", load_if.load_ready, 1'b1);
        check("hold_nib_a", digit_nibble, 4'hA);
        cycle_end();
        load_if.load_valid = 1'b0;
        @(negedge clk); compare_model();
        check("hold_taken", load_if.load_ready, 1'b0);
        cycle_end();
        run_until(160);
        @(negedge clk); compare_model();
        check("hold_still_a", digit_nibble, 4'hA);
        cycle_end();
        run_until(168);
        @(negedge clk); compare_model();
        check("hold_now_b", digit_nibble, 4'hB);
        cycle_end();

        // Load accepted exactly on the frame_done cycle waits a full frame.
        run_until(195);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h5555;
        @(negedge clk); compare_model();
        check("edge_fd", frame_done, 1'b1);
        check("edge_ready", load_if.load_ready, 1'b1);
        cycle_end();
        load_if.load_valid = 1'b0;
        @(negedge clk); compare_model();
        check("edge_no_bypass", digit_nibble, 4'hB);
        check("edge_pending", load_if.load_ready, 1'b0);
        cycle_end();
        run_until(210);
        @(negedge clk); compare_model();
        check("edge_mid_b", digit_nibble, 4'hB);
        cycle_end();
        run_until(224);
        @(negedge clk); compare_model();
        check("edge_applied", digit_nibble, 4'h5);
        cycle_end();

        // Disabled digits keep their slots.
        digit_en = 4'b0101;
        run_until(233);
        @(negedge clk); compare_model();
        check("en_d1_off", anode, 4'hF);
        cycle_end();
        run_until(240);
        @(negedge clk); compare_model();
        check("en_d2_on", anode, 4'hB);
        cycle_end();
        run_until(247);
        @(negedge clk); compare_model();
        check("en_d3_off", anode, 4'hF);
        cycle_end();
        run_until(251);
        @(negedge clk); compare_model();
        check("en_fd_a", frame_done, 1'b1);
        cycle_end();
        run_until(279);
        @(negedge clk); compare_model();
        check("en_fd_b", frame_done, 1'b1);
        cycle_end();

        // Reset during SHOW of digit 2 discards a pending load.
        digit_en = 4'hF;
        run_until(281);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h9999;
        step();
        load_if.load_valid = 1'b0;
        run_until(296);
        rst = 1'b1;
        @(negedge clk); compare_model();
        check("rst_pre_anode", anode, 4'hB);
        check("rst_pre_pending", load_if.load_ready, 1'b0);
        cycle_end();
        rst = 1'b0;
        @(negedge clk); compare_model();
        check("rst_anode", anode, 4'hF);
        check("rst_idx", digit_idx, 2'd0);
        check("rst_nib", digit_nibble, 4'h0);
        check("rst_ready", load_if.load_ready, 1'b1);
        cycle_end();
        run_until(28);
        @(negedge clk); compare_model();
        check("rst_discarded", digit_nibble, 4'h0);
        cycle_end();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst                = ($urandom_range(0, 199) == 0);
            load_if.load_valid = ($urandom_range(0, 2) == 0);
            load_if.load_data  = 16'($urandom);
            if ($urandom_range(0, 39) == 0) digit_en = 4'($urandom);
            step();
        end
        rst = 1'b0;
        load_if.load_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
